adder_share_arbiter: RTL



---
 rtl/adder_share_arbiter_pkg.sv | 36 +++
 rtl/adder_share_arbiter_rr_arbiter.sv | 48 ++++
 rtl/han_carlson_adder.sv | 66 ++++++
 rtl/adder_share_arbiter.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/adder_share_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | adder_arb_pkg : shared types and round-robin search for adder_share_arbiter |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package adder_arb_pkg;

  localparam int MAX_REQ = 16;
  localparam int PICK_W  = $clog2(MAX_REQ);

  typedef enum logic [0:0] {EMPTY = 1'b0, FULL = 1'b1} result_state_e;

  typedef struct packed {
    logic              found;
    logic [PICK_W-1:0] idx;
  } pick_t;

  // First asserted valid at or after ptr, wrapping modulo num.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                    input logic [PICK_W-1:0] ptr,
                                    input int num);
    pick_t r;
    int    j;
    r = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      j = (int'(ptr) + i) % num;
      if ((i < num) && !r.found && valid[j]) begin
        r.found = 1'b1;
        r.idx   = PICK_W'(j);
      end
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/adder_share_arbiter_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rr_arbiter : round-robin pointer and one-hot grant for the shared adder     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] valid,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    idx,
  output logic               found
);
  import adder_arb_pkg::*;

  logic [ID_W-1:0]    r_ptr;
  logic [MAX_REQ-1:0] w_valid_ext;
  pick_t              w_pick;

  always_comb begin
    w_valid_ext                = '0;
    w_valid_ext[NUM_REQ-1:0]   = valid;
    w_pick                     = rr_pick(w_valid_ext, PICK_W'(r_ptr), NUM_REQ);
    found                      = enable && w_pick.found;
    grant                      = '0;
    idx                        = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (found && (w_pick.idx == PICK_W'(i))) begin
        grant[i] = 1'b1;
        idx      = ID_W'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (found) begin
      r_ptr <= (idx == ID_W'(NUM_REQ - 1)) ? '0 : idx + ID_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/han_carlson_adder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Han_carlson_adder : radix-2 Han-Carlson parallel-prefix adder with carry-in |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module Han_carlson_adder #(
  parameter int WIDTH   = 16,
  parameter int VALENCY = 2
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int LV = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  if (VALENCY != 2) begin : g_valency_check
    $error("Han_carlson_adder only implements VALENCY=2");
  end

  logic w_g [0:LV][0:WIDTH-1];
  logic w_p [0:LV][0:WIDTH-1];
  logic w_c [0:WIDTH-1];

  // Carry-in is folded into bit 0 so every prefix is a plain carry out.
  for (genvar i = 0; i < WIDTH; i++) begin : g_pre
    if (i == 0) begin : g_b0
      assign w_g[0][i] = (a[i] & b[i]) | ((a[i] ^ b[i]) & cin);
    end else begin : g_bn
      assign w_g[0][i] = a[i] & b[i];
    end
    assign w_p[0][i] = a[i] ^ b[i];
  end

  // Odd bits only: pair with the even neighbour, then Kogge-Stone on odds.
  for (genvar k = 1; k <= LV; k++) begin : g_lvl
    localparam int D = 1 << (k - 1);
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if ((i % 2 == 1) && (i >= D)) begin : g_op
        assign w_g[k][i] = w_g[k-1][i] | (w_p[k-1][i] & w_g[k-1][i-D]);
        assign w_p[k][i] = w_p[k-1][i] & w_p[k-1][i-D];
      end else begin : g_pass
        assign w_g[k][i] = w_g[k-1][i];
        assign w_p[k][i] = w_p[k-1][i];
      end
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_post
    if ((i % 2 == 0) && (i > 0)) begin : g_even
      assign w_c[i] = w_g[LV][i] | (w_p[LV][i] & w_g[LV][i-1]);
    end else begin : g_odd
      assign w_c[i] = w_g[LV][i];
    end
    if (i == 0) begin : g_s0
      assign sum[i] = w_p[0][i] ^ cin;
    end else begin : g_sn
      assign sum[i] = w_p[0][i] ^ w_c[i-1];
    end
  end

  assign cout = w_c[WIDTH-1];

endmodule
`default_nettype wire

// File: rtl/adder_share_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | adder_share_arbiter : round-robin sharing of one Han_carlson_adder with a   |
// | registered, ID-tagged result. Define ADDER_ARB_STATS_EN for counters.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module adder_share_arbiter #(
  parameter int WIDTH   = 16,
  parameter int VALENCY = 2,
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ-1:0]       req_cin,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [WIDTH-1:0]         rsp_sum,
  output logic                     rsp_cout
`ifdef ADDER_ARB_STATS_EN
  ,
  input  logic                     stat_clear,
  output logic [31:0]              stat_grants,
  output logic [31:0]              stat_stall
`endif
);
  import adder_arb_pkg::*;

  result_state_e    r_state, w_state_nxt;
  logic             w_can_accept, w_grant_any, w_load;
  logic [ID_W-1:0]  w_gidx;
  logic [WIDTH-1:0] w_a, w_b, w_sum;
  logic             w_cin, w_cout;
  logic [ID_W-1:0]  r_id;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;

  assign w_can_accept = (r_state == EMPTY) || rsp_ready;

  // Gating with rst keeps req_ready low for the whole reset assertion.
  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .clk    (clk),
    .rst    (rst),
    .valid  (req_valid),
    .enable (w_can_accept && !rst),
    .grant  (req_ready),
    .idx    (w_gidx),
    .found  (w_grant_any)
  );

  always_comb begin
    w_a   = '0;
    w_b   = '0;
    w_cin = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) begin
        w_a   = req_a[i*WIDTH +: WIDTH];
        w_b   = req_b[i*WIDTH +: WIDTH];
        w_cin = req_cin[i];
      end
    end
  end

  Han_carlson_adder #(.WIDTH(WIDTH), .VALENCY(VALENCY)) u_add (
    .a    (w_a),
    .b    (w_b),
    .cin  (w_cin),
    .sum  (w_sum),
    .cout (w_cout)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      EMPTY: begin
        if (w_grant_any) begin
          w_state_nxt = FULL;
          w_load      = 1'b1;
        end
      end
      FULL: begin
        if (rsp_ready) begin
          w_state_nxt = w_grant_any ? FULL : EMPTY;
          w_load      = w_grant_any;
        end
      end
      default: w_state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= EMPTY;
      r_id    <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_id   <= w_gidx;
        r_sum  <= w_sum;
        r_cout <= w_cout;
      end
    end
  end

  assign rsp_valid = (r_state == FULL);
  assign rsp_id    = r_id;
  assign rsp_sum   = r_sum;
  assign rsp_cout  = r_cout;

`ifdef ADDER_ARB_STATS_EN
  logic [31:0] r_stat_grants, r_stat_stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stat_grants <= '0;
      r_stat_stall  <= '0;
    end else if (stat_clear) begin
      r_stat_grants <= '0;
      r_stat_stall  <= '0;
    end else begin
      if (w_grant_any && (r_stat_grants != 32'hFFFF_FFFF))
        r_stat_grants <= r_stat_grants + 32'd1;
      if ((|req_valid) && !w_can_accept && (r_stat_stall != 32'hFFFF_FFFF))
        r_stat_stall <= r_stat_stall + 32'd1;
    end
  end

  assign stat_grants = r_stat_grants;
  assign stat_stall  = r_stat_stall;
`endif

endmodule
`default_nettype wire
